// File: rtl/powerup_pkg.sv
// Shared power-up types, screen constants and the X-wrap helper.
package powerup_pkg;

  typedef enum logic {PU_TURBO, PU_GODMODE} powerup_t;
  typedef enum {WAIT, FALLING} spawner_state_t;

  localparam int unsigned SPRITE_W = 16;
  localparam int unsigned SPRITE_H = 16;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Folds a 10-bit random value into 0..xMax with a single subtraction.
  function automatic logic [10:0] wrapX(input logic [9:0] raw, input int unsigned xMax);
    logic [10:0] x;
    x = {1'b0, raw};
    if (32'(raw) > xMax) x = x - 11'(xMax + 1);
    return x;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, shared by randomised objects.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (reset) out <= SEED;
    else       out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
  end

endmodule

// File: rtl/powerup_spawner.sv
// Spawns one falling Turbo/GodMode power-up at a time and emits typed collection pulses.
// Optional POWERUP_PAUSE_EN adds a pause input that freezes frame-driven activity.
module powerup_spawner
  import powerup_pkg::*;
#(
  parameter int unsigned SPAWN_INTERVAL_FRAMES = 300,
  parameter int unsigned FALL_SPEED            = 2,
  parameter int unsigned START_Y               = 0,
  parameter int unsigned BOTTOM_LIMIT          = 463,
  parameter int unsigned X_MAX                 = 623,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               powerupHit,
`ifdef POWERUP_PAUSE_EN
  input  logic               pause,
`endif
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               powerupType,
  output logic               powerupVisible,
  output logic               turboCollected,
  output logic               godModeCollected
);

  localparam int unsigned CNT_W = $clog2(SPAWN_INTERVAL_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_INTERVAL_FRAMES - 1);

  spawner_state_t   state;
  logic [CNT_W-1:0] frameCnt;
  powerup_t         typeReg;
  logic [15:0]      lfsrOut;
  logic             frameTick;
  logic [10:0]      nextY;
  logic             unusedLfsrBits;

  lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsrOut)
  );

  assign unusedLfsrBits = ^lfsrOut[14:10];

`ifdef POWERUP_PAUSE_EN
  assign frameTick = startOfFrame & ~pause;
`else
  assign frameTick = startOfFrame;
`endif

  assign nextY       = topLeftY + 11'(FALL_SPEED);
  assign powerupType = typeReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= WAIT;
      frameCnt         <= '0;
      topLeftX         <= '0;
      topLeftY         <= 11'(START_Y);
      typeReg          <= PU_TURBO;
      powerupVisible   <= 1'b0;
      turboCollected   <= 1'b0;
      godModeCollected <= 1'b0;
    end else begin
      turboCollected   <= 1'b0;
      godModeCollected <= 1'b0;
      case (state)
        WAIT: begin
          if (frameTick) begin
            if (frameCnt == CNT_LAST) begin
              topLeftX       <= wrapX(lfsrOut[9:0], X_MAX);
              topLeftY       <= 11'(START_Y);
              typeReg        <= powerup_t'(lfsrOut[15]);
              frameCnt       <= '0;
              powerupVisible <= 1'b1;
              state          <= FALLING;
            end else begin
              frameCnt <= frameCnt + 1'b1;
            end
          end
        end
        FALLING: begin
          // A hit outranks frame movement, so a catch on the last row is never a miss.
          if (powerupHit) begin
            turboCollected   <= (typeReg == PU_TURBO);
            godModeCollected <= (typeReg == PU_GODMODE);
            powerupVisible   <= 1'b0;
            frameCnt         <= '0;
            state            <= WAIT;
          end else if (frameTick) begin
            if (nextY > 11'(BOTTOM_LIMIT)) begin
              powerupVisible <= 1'b0;
              state          <= WAIT;
            end else begin
              topLeftY <= nextY;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_powerup_spawner.sv
// Self-checking bench for powerup_spawner; define POWERUP_PAUSE_EN to exercise pause.
module tb_powerup_spawner;
  import powerup_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic startOfFrame = 1'b0;
  logic powerupHit = 1'b0;
`ifdef POWERUP_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic signed [10:0] topLeftX, topLeftY;
  logic powerupType, powerupVisible, turboCollected, godModeCollected;

  powerup_spawner #(
    .SPAWN_INTERVAL_FRAMES(N),
    .FALL_SPEED(2),
    .START_Y(0),
    .BOTTOM_LIMIT(463),
    .X_MAX(623),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .powerupHit(powerupHit),
`ifdef POWERUP_PAUSE_EN
    .pause(pause),
`endif
    .topLeftX(topLeftX),
    .topLeftY(topLeftY),
    .powerupType(powerupType),
    .powerupVisible(powerupVisible),
    .turboCollected(turboCollected),
    .godModeCollected(godModeCollected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vis;
    logic        typ;
    logic        tc;
    logic        gc;
    logic [10:0] x;
    logic [10:0] y;
  } outs_t;

  typedef struct {
    logic [9:0]  raw;
    logic [10:0] expX;
  } wrapVec_t;

  outs_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] refL;
  logic        mFall = 1'b0;
  int unsigned mCnt = 0;
  logic [10:0] mX = '0, mY = '0;
  logic        mType = 1'b0, mVis = 1'b0;

  always @(posedge clk) begin
    if (reset) refL <= 16'hACE1;
    else       refL <= {refL[14:0], refL[15] ^ refL[13] ^ refL[12] ^ refL[10]};
  end

  function automatic logic [10:0] refWrap(input logic [9:0] r);
    if (r > 10'd623) return {1'b0, r} - 11'd624;
    return {1'b0, r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic sof, input logic hit, input logic rst, input logic pse);
    outs_t e;
    logic tc, gc, sofE;
    logic [10:0] ny;
    @(negedge clk);
    startOfFrame = sof;
    powerupHit   = hit;
    reset        = rst;
`ifdef POWERUP_PAUSE_EN
    pause = pse;
    sofE  = sof & ~pse;
`else
    sofE  = sof | (pse & 1'b0);
`endif
    tc = 1'b0;
    gc = 1'b0;
    if (rst) begin
      mFall = 1'b0; mCnt = 0; mX = '0; mY = '0; mType = 1'b0; mVis = 1'b0;
    end else if (!mFall) begin
      if (sofE) begin
        if (mCnt == N - 1) begin
          mX = refWrap(refL[9:0]); mY = '0; mType = refL[15];
          mCnt = 0; mVis = 1'b1; mFall = 1'b1;
        end else begin
          mCnt++;
        end
      end
    end else if (hit) begin
      tc = ~mType; gc = mType; mVis = 1'b0; mFall = 1'b0; mCnt = 0;
    end else if (sofE) begin
      ny = mY + 11'd2;
      if (ny > 11'd463) begin
        mVis = 1'b0; mFall = 1'b0;
      end else begin
        mY = ny;
      end
    end
    e = '{vis: mVis, typ: mType, tc: tc, gc: gc, x: mX, y: mY};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("visible", 32'(powerupVisible), 32'(e.vis));
    check("type", 32'(powerupType), 32'(e.typ));
    check("turbo", 32'(turboCollected), 32'(e.tc));
    check("godMode", 32'(godModeCollected), 32'(e.gc));
    check("x", 32'($unsigned(topLeftX)), 32'(e.x));
    check("y", 32'($unsigned(topLeftY)), 32'(e.y));
  endtask

  task automatic frame(input int unsigned n, input logic pse);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, pse);
      step(1'b0, 1'b0, 1'b0, pse);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wrapVec_t vecs[5];
    int unsigned tries;

    vecs[0] = '{raw: 10'd1000, expX: 11'd376};
    vecs[1] = '{raw: 10'd623,  expX: 11'd623};
    vecs[2] = '{raw: 10'd624,  expX: 11'd0};
    vecs[3] = '{raw: 10'd0,    expX: 11'd0};
    vecs[4] = '{raw: 10'd1023, expX: 11'd399};

    // Reset state
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstVisible", 32'(powerupVisible), 32'd0);
    check("rstY", 32'($unsigned(topLeftY)), 32'd0);
    check("rstX", 32'($unsigned(topLeftX)), 32'd0);

    for (int i = 0; i < 5; i++)
      check("wrapX", 32'(wrapX(vecs[i].raw, 623)), 32'(vecs[i].expX));

    // Spawn on the third frame
    frame(2, 1'b0);
    check("noSpawnEarly", 32'(powerupVisible), 32'd0);
    frame(1, 1'b0);
    check("spawnVisible", 32'(powerupVisible), 32'd1);
    check("spawnXRange", 32'($unsigned(topLeftX) <= 11'd623), 32'd1);

    // Fall to the bottom and miss
    frame(231, 1'b0);
    check("fallY462", 32'($unsigned(topLeftY)), 32'd462);
    frame(1, 1'b0);
    check("missVisible", 32'(powerupVisible), 32'd0);
    check("missNoPulse", 32'(turboCollected | godModeCollected), 32'd0);

    // GodMode spawn, hit at Y=100
    frame(2, 1'b0);
    tries = 0;
    while (refL[15] !== 1'b1 && tries < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      tries++;
    end
    check("godWait", 32'(tries < 200), 32'd1);
    frame(1, 1'b0);
    check("godType", 32'(powerupType), 32'd1);
    frame(50, 1'b0);
    check("y100", 32'($unsigned(topLeftY)), 32'd100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("godPulse", 32'(godModeCollected), 32'd1);
    check("godNoTurbo", 32'(turboCollected), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("godPulseOnce", 32'(godModeCollected), 32'd0);
    frame(3, 1'b0);
    check("respawn", 32'(powerupVisible), 32'd1);

    // Hit together with frame at the last row
    frame(231, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hitBeatsMiss", 32'(turboCollected | godModeCollected), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("waitHitIgnored", 32'(turboCollected | godModeCollected), 32'd0);

    // Back-to-back hits
    frame(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("b2bSinglePulse", 32'(turboCollected | godModeCollected), 32'd0);

    // Reset one cycle after hit, and reset coincident with hit
    frame(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rstClearsPulse", 32'(turboCollected | godModeCollected), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    frame(3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("rstSuppressPulse", 32'(turboCollected | godModeCollected), 32'd0);
    check("rstHidesObject", 32'(powerupVisible), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef POWERUP_PAUSE_EN
    frame(3, 1'b0);
    frame(5, 1'b0);
    frame(10, 1'b1);
    check("pauseHoldsY", 32'($unsigned(topLeftY)), 32'd10);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("pauseHitAccepted", 32'(turboCollected | godModeCollected), 32'd1);
`endif

    check("scoreboardEmpty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/powerup_spawner.md
Name: powerup_spawner

Overview:
- Producer end of the power-up path: periodically spawns one falling power-up object (Turbo or GodMode) at a pseudo-random X position.
- Moves the object down once per frame and exposes its position and type to the drawing/hit-detection logic.
- On a player hit it emits a one-cycle typed collection pulse; these pulses drive the TurboCollision/GodModeCollision inputs of the power-up manager.
- At most one power-up exists on screen at a time.

Parameters:
SPAWN_INTERVAL_FRAMES, 300, frames spent in WAIT before a spawn (≥1)
FALL_SPEED, 2, pixels added to Y per frame while falling
START_Y, 0, Y coordinate at spawn
BOTTOM_LIMIT, 463, object is missed when Y exceeds this (screen 479 minus 16-pixel sprite height)
X_MAX, 623, largest legal top-left X (screen 639 minus 16-pixel sprite width)
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
powerupHit  in  1  one-cycle pulse from hit detector: player overlapped this object
topLeftX  out  11  object top-left X, signed
topLeftY  out  11  object top-left Y, signed
powerupType  out  1  0 = Turbo, 1 = GodMode; valid while powerupVisible
powerupVisible  out  1  object exists and must be drawn
turboCollected  out  1  one-cycle pulse, Turbo picked up
godModeCollected  out  1  one-cycle pulse, GodMode picked up

Behaviour:
- All state is registered; the only clock is clk. reset is sampled on the rising edge of clk.
- Reset values:
  - FSM state = WAIT; frame counter = 0; LFSR = LFSR_SEED.
  - topLeftX = 0, topLeftY = START_Y.
  - powerupType = 0, powerupVisible = 0, both collected pulses = 0.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every clock regardless of state, so spawn values depend on elapsed time.
- WAIT state:
  - The frame counter increments on each startOfFrame.
  - When a startOfFrame arrives with counter == SPAWN_INTERVAL_FRAMES-1, the next cycle:
    - loads X from the current LFSR value, as defined under "X derivation";
    - sets topLeftY = START_Y and powerupType = lfsr[15];
    - clears the counter, sets powerupVisible = 1 and enters FALLING.
  - powerupHit is ignored in WAIT.
- X derivation:
  - x = lfsr[9:0].
  - If x > X_MAX, then x = x − (X_MAX+1).
  - The result is always in 0..X_MAX and is zero-extended to 11 bits.
- FALLING state:
  - On startOfFrame: nextY = topLeftY + FALL_SPEED, using 11-bit arithmetic.
    - If nextY > BOTTOM_LIMIT: missed. powerupVisible goes to 0 next cycle, the state returns to WAIT, and no pulse is emitted.
    - Otherwise topLeftY = nextY.
  - On powerupHit:
    - the next cycle asserts exactly one of turboCollected / godModeCollected for exactly one cycle, selected by powerupType;
    - powerupVisible = 0 in the same cycle; the state becomes WAIT and the counter is cleared.
  - powerupHit and startOfFrame in the same cycle: the hit wins, Y is not updated and the miss check is skipped.
- Collection pulses are never asserted outside the cycle following an accepted hit. Back-to-back powerupHit pulses produce only one collection pulse.
- Latency: input pulse → output change = 1 clock.
- Reset asserted mid-fall: the object disappears on the next edge, and any in-flight collection pulse is suppressed.

Optional Feature:
- Macro: POWERUP_PAUSE_EN.
- When defined:
  - adds input port pause (1 bit);
  - while pause = 1, startOfFrame is ignored, so the frame counter and Y movement freeze;
  - powerupHit is still accepted;
  - the LFSR keeps running.
- When undefined: no pause port; behaviour exactly as above.

Decomposition:
- Shared package powerup_pkg:
  - typedef enum logic {PU_TURBO, PU_GODMODE} powerup_t;
  - typedef enum {WAIT, FALLING} spawner_state_t;
  - constants SPRITE_W = 16, SPRITE_H = 16, SCREEN_W = 640, SCREEN_H = 480.
- One sub-module: lfsr16.
  - Parameter SEED; ports clk, reset, out[15:0].
  - Reusable by other randomised game objects.

Test Plan:
1. SPAWN_INTERVAL_FRAMES = 3, LFSR_SEED = 16'hACE1 → after reset, the 3rd startOfFrame makes powerupVisible = 1 one cycle later, with topLeftY = 0, topLeftX ≤ 623, and type = reference-model lfsr[15].
2. Force lfsr[9:0] = 1000 at spawn → topLeftX = 376; force 623 → 623; force 624 → 0.
3. FALLING from Y = 0, FALL_SPEED = 2, BOTTOM_LIMIT = 463 → after 231 frames Y = 462; the 232nd frame drops visibility, returns to WAIT, and both pulses stay 0.
4. Type = GodMode, powerupHit at Y = 100 → godModeCollected = 1 for exactly one cycle, turboCollected = 0, powerupVisible = 0, next spawn after 3 more frames.
5. powerupHit and startOfFrame in the same cycle at Y = 462 → a collection pulse fires, not a miss; a powerupHit in WAIT produces no pulse.
6. Reset pulsed one cycle after powerupHit → no collection pulse, all outputs at reset values; with POWERUP_PAUSE_EN, pause = 1 over 10 frames leaves Y unchanged.
